pic_control_unit: RTL and testbench

Synchronous, parametrised command and acknowledge controller for the programmable interrupt controller. It handles ICW1–ICW4 initialisation, OCW1–OCW3 operation commands, IRR/ISR/IMR bookkeeping and the two-pulse INTA vector sequence with optional auto-EOI. It replaces the unclocked strobe-edge control logic. It sits between the bus interface (wr_n/rd_n/a0/data) and the CPU interrupt pins (int_o/inta_n).

---
 rtl/pic_pkg.sv | 20 ++
 rtl/pic_prio_enc.sv | 15 +
 rtl/pic_control_unit.sv | 158 +++++++++++++++
 tb/tb_pic_control_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM types and command decode constants for the PIC control unit.
package pic_pkg;
  typedef enum logic [2:0] {CFG_ICW1, CFG_ICW2, CFG_ICW3, CFG_ICW4, CFG_READY} cfg_state_t;
  typedef enum logic [1:0] {ACK_IDLE, ACK_1, ACK_2} ack_state_t;
  localparam int ICW1_BIT = 4;
  localparam int LTIM_BIT = 3;
  localparam int SNGL_BIT = 1;
  localparam int IC4_BIT = 0;
  localparam int AEOI_BIT = 1;
  localparam logic [1:0] OCW2_SEL = 2'b00;
  localparam logic [1:0] OCW3_SEL = 2'b01;
  localparam logic [2:0] EOI_NS = 3'b001;
  localparam logic [2:0] EOI_SP = 3'b011;
  localparam logic [1:0] RD_IRR = 2'b10;
  localparam logic [1:0] RD_ISR = 2'b11;
  // A spurious acknowledge reports the lowest-priority line.
  function automatic int ack_spurious(input int num_irq);
    return num_irq - 1;
  endfunction
endpackage

// File: rtl/pic_prio_enc.sv
// pic_prio_enc: lowest-set-index priority encoder with valid flag.
module pic_prio_enc #(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (req[i]) idx = IDX_W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/pic_control_unit.sv
// pic_control_unit: clocked ICW/OCW command decode, IRR/ISR/IMR bookkeeping
// and two-pulse INTA vector sequencing for the interrupt controller.
module pic_control_unit import pic_pkg::*; #(
  parameter int NUM_IRQ = 8,
  parameter bit EDGE_DEFAULT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_n,
  input  logic               rd_n,
  input  logic               a0,
  input  logic [7:0]         din,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               inta_n,
  output logic [7:0]         dout,
  output logic               dout_en,
  output logic               int_o,
  output logic               init_done
);
  localparam int IDX_W = $clog2(NUM_IRQ);
  localparam int BASE_W = 8 - IDX_W;
  cfg_state_t cfg_q, cfg_n;
  ack_state_t ack_q, ack_n;
  logic [NUM_IRQ-1:0] imr, imr_n, isr, isr_n, irr, irr_n, hist, hist_n;
  logic [NUM_IRQ-1:0] elig, below, ack_bit, irq_rise;
  logic [BASE_W-1:0] base, base_n;
  logic [IDX_W-1:0] idx_q, idx_n, el_idx, isr_idx;
  logic el_v, isr_v, spur_q, spur_n, ltim, ltim_n, sel_isr, sel_n;
  logic sngl, sngl_n, ic4, ic4_n, aeoi, aeoi_n;
  logic wr_q, inta_q, commit, icw1, wr_ok, inta_fall, inta_rise;
  logic [7:0] dout_n;
  logic dout_en_n, int_n;
  assign commit = !wr_q && wr_n;
  assign icw1 = commit && !a0 && din[ICW1_BIT];
  assign wr_ok = commit && ack_q == ACK_IDLE;
  assign inta_fall = inta_q && !inta_n;
  assign inta_rise = !inta_q && inta_n;
  assign irq_rise = irq_i & ~hist;
  assign init_done = cfg_q == CFG_READY;
  pic_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_isr_enc (.req(isr), .idx(isr_idx), .valid(isr_v));
  pic_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_el_enc (.req(elig), .idx(el_idx), .valid(el_v));
  // Only lines strictly above the highest in-service level may interrupt.
  always_comb begin
    below = '0;
    for (int i = 0; i < NUM_IRQ; i++) below[i] = !isr_v || i < int'(isr_idx);
  end
  assign elig = irr & ~imr & below;
  assign ack_bit = NUM_IRQ'(1) << el_idx;
  always_comb begin
    cfg_n = cfg_q;
    ack_n = ack_q;
    imr_n = imr;
    isr_n = isr;
    irr_n = ltim ? irq_i : irr | irq_rise;
    hist_n = irq_i;
    base_n = base;
    idx_n = idx_q;
    spur_n = spur_q;
    ltim_n = ltim;
    sel_n = sel_isr;
    sngl_n = sngl;
    ic4_n = ic4;
    aeoi_n = aeoi;
    dout_n = dout;
    dout_en_n = 1'b0;
    if (wr_ok && a0 && cfg_q == CFG_ICW2) begin
      base_n = din[7:IDX_W];
      cfg_n = !sngl ? CFG_ICW3 : ic4 ? CFG_ICW4 : CFG_READY;
    end else if (wr_ok && a0 && cfg_q == CFG_ICW3) begin
      cfg_n = ic4 ? CFG_ICW4 : CFG_READY;
    end else if (wr_ok && a0 && cfg_q == CFG_ICW4) begin
      aeoi_n = din[AEOI_BIT];
      cfg_n = CFG_READY;
    end else if (wr_ok && cfg_q == CFG_READY) begin
      if (a0) imr_n = din[NUM_IRQ-1:0];
      else if (din[4:3] == OCW2_SEL && din[7:5] == EOI_NS) isr_n = isr & ~(NUM_IRQ'(1) << isr_idx);
      else if (din[4:3] == OCW2_SEL && din[7:5] == EOI_SP) isr_n = isr & ~(NUM_IRQ'(1) << din[2:0]);
      else if (din[4:3] == OCW3_SEL && din[1:0] == RD_IRR) sel_n = 1'b0;
      else if (din[4:3] == OCW3_SEL && din[1:0] == RD_ISR) sel_n = 1'b1;
    end
    // The acknowledge set is applied after any same-cycle EOI so the set wins.
    if (ack_q == ACK_IDLE && inta_fall && cfg_q == CFG_READY) begin
      ack_n = ACK_1;
      spur_n = !el_v;
      idx_n = el_v ? el_idx : IDX_W'(ack_spurious(NUM_IRQ));
      if (el_v) isr_n = isr_n | ack_bit;
      if (el_v && !ltim) irr_n = (irr & ~ack_bit) | irq_rise;
    end else if (ack_q == ACK_1 && inta_fall) begin
      ack_n = ACK_2;
      dout_n = {base, idx_q};
      dout_en_n = 1'b1;
    end else if (ack_q == ACK_2) begin
      dout_en_n = !inta_rise;
      if (inta_rise) ack_n = ACK_IDLE;
      if (inta_rise && aeoi && !spur_q) isr_n = isr & ~(NUM_IRQ'(1) << idx_q);
    end else if (ack_q == ACK_IDLE && !rd_n) begin
      dout_n = a0 ? 8'(imr) : 8'(sel_isr ? isr : irr);
      dout_en_n = 1'b1;
    end
    if (icw1) begin
      cfg_n = CFG_ICW2;
      ack_n = ACK_IDLE;
      imr_n = '0;
      isr_n = '0;
      irr_n = '0;
      hist_n = '0;
      ltim_n = din[LTIM_BIT];
      sel_n = 1'b0;
      sngl_n = din[SNGL_BIT];
      ic4_n = din[IC4_BIT];
      aeoi_n = 1'b0;
      dout_en_n = 1'b0;
    end
  end
  assign int_n = cfg_q == CFG_READY && |elig && ack_q == ACK_IDLE && !icw1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg_q <= CFG_ICW1;
      ack_q <= ACK_IDLE;
      imr <= '0;
      isr <= '0;
      irr <= '0;
      hist <= '0;
      base <= '0;
      idx_q <= '0;
      spur_q <= 1'b0;
      ltim <= !EDGE_DEFAULT;
      sel_isr <= 1'b0;
      sngl <= 1'b0;
      ic4 <= 1'b0;
      aeoi <= 1'b0;
      wr_q <= 1'b1;
      inta_q <= 1'b1;
      dout <= '0;
      dout_en <= 1'b0;
      int_o <= 1'b0;
    end else begin
      cfg_q <= cfg_n;
      ack_q <= ack_n;
      imr <= imr_n;
      isr <= isr_n;
      irr <= irr_n;
      hist <= hist_n;
      base <= base_n;
      idx_q <= idx_n;
      spur_q <= spur_n;
      ltim <= ltim_n;
      sel_isr <= sel_n;
      sngl <= sngl_n;
      ic4 <= ic4_n;
      aeoi <= aeoi_n;
      wr_q <= wr_n;
      inta_q <= inta_n;
      dout <= dout_n;
      dout_en <= dout_en_n;
      int_o <= int_n;
    end
endmodule

// File: tb/tb_pic_control_unit.sv
// tb_pic_control_unit: directed stimulus with a register-level reference model of the PIC.
module tb_pic_control_unit;
  logic clk = 0, rst_n = 0, wr_n = 1, rd_n = 1, a0 = 0, inta_n = 1;
  logic [7:0] din = 0, irq_i = 0, dout;
  logic dout_en, int_o, init_done;
  int compared = 0, mismatched = 0;
  bit chk_en = 0;
  bit [7:0] m_imr, m_isr, m_irr, m_base;
  bit m_ltim, m_sel, m_aeoi, m_done, m_need3, m_need4;
  int m_step;

  pic_control_unit #(.NUM_IRQ(8), .EDGE_DEFAULT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .din(din),
    .irq_i(irq_i), .inta_n(inta_n), .dout(dout), .dout_en(dout_en),
    .int_o(int_o), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_imr = 0; m_isr = 0; m_irr = 0; m_base = 0;
    m_ltim = 0; m_sel = 0; m_aeoi = 0; m_done = 0; m_need3 = 0; m_need4 = 0; m_step = 1;
  endtask

  // Requests above the highest in-service level, minus masked ones.
  function automatic bit [7:0] m_elig();
    int hi;
    hi = 8;
    for (int i = 7; i >= 0; i--) if (m_isr[i]) hi = i;
    m_elig = 0;
    for (int i = 0; i < hi; i++) if (m_irr[i] && !m_imr[i]) m_elig[i] = 1;
  endfunction

  function automatic bit m_int();
    return m_done && m_elig() != 0;
  endfunction

  task automatic m_write(input bit a, input bit [7:0] d);
    if (!a && d[4]) begin
      m_imr = 0; m_isr = 0; m_irr = 0; m_ltim = d[3]; m_sel = 0; m_aeoi = 0;
      m_need3 = !d[1]; m_need4 = d[0]; m_step = 2;
    end else if (a && m_step == 2) begin
      m_base = d; m_step = m_need3 ? 3 : m_need4 ? 4 : 5;
    end else if (a && m_step == 3) m_step = m_need4 ? 4 : 5;
    else if (a && m_step == 4) begin
      m_aeoi = d[1]; m_step = 5;
    end else if (m_step == 5) begin
      if (a) m_imr = d;
      else if (d[4:3] == 0 && d[7:5] == 1) begin
        for (int i = 0; i < 8; i++) if (m_isr[i]) begin m_isr[i] = 0; break; end
      end else if (d[4:3] == 0 && d[7:5] == 3) m_isr[d[2:0]] = 0;
      else if (d[4:3] == 1 && d[1:0] == 2) m_sel = 0;
      else if (d[4:3] == 1 && d[1:0] == 3) m_sel = 1;
    end
    m_done = m_step == 5;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("int_o", 8'(int_o), 8'(m_int()));
    chk("init_done", 8'(init_done), 8'(m_done));
    chk("dout_en_idle", 8'(dout_en), 8'h00);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    chk_en = 1; tick(n); chk_en = 0;
  endtask

  task automatic wr(input bit a, input bit [7:0] d);
    a0 = a; din = d; wr_n = 0; tick(2);
    wr_n = 1; m_write(a, d); tick(3);
    idle(2);
  endtask

  task automatic rd(input bit a, input bit [7:0] exp, input string name);
    bit [7:0] mv;
    mv = a ? m_imr : (m_sel ? m_isr : m_irr);
    a0 = a; rd_n = 0; tick(2);
    chk(name, dout, exp);
    chk({name, "_model"}, dout, mv);
    chk({name, "_en"}, 8'(dout_en), 8'h01);
    rd_n = 1; tick(2);
    idle(2);
  endtask

  task automatic set_irq(input int i, input bit v);
    if (m_ltim) m_irr[i] = v;
    else if (v && !irq_i[i]) m_irr[i] = 1;
    irq_i[i] = v; tick(3);
    idle(2);
  endtask

  task automatic inta_seq(input bit [7:0] exp);
    bit [7:0] e, vec;
    int idx;
    bit sp;
    e = m_elig(); sp = e == 0; idx = 7;
    for (int i = 7; i >= 0; i--) if (e[i]) idx = i;
    if (!sp) begin m_isr[idx] = 1; if (!m_ltim) m_irr[idx] = 0; end
    vec = {m_base[7:3], 3'(idx)};
    inta_n = 0; tick(2); inta_n = 1; tick(2);
    inta_n = 0; tick(3);
    chk("vector", dout, exp);
    chk("vector_model", dout, vec);
    chk("vector_en", 8'(dout_en), 8'h01);
    inta_n = 1; tick(3);
    if (m_aeoi && !sp) m_isr[idx] = 0;
    chk("vector_off", 8'(dout_en), 8'h00);
    idle(2);
  endtask

  initial begin
    m_reset();
    tick(3);
    chk("rst_dout", dout, 8'h00);
    chk("rst_dout_en", 8'(dout_en), 8'h00);
    chk("rst_int_o", 8'(int_o), 8'h00);
    chk("rst_init_done", 8'(init_done), 8'h00);
    rst_n = 1; tick(2); idle(3);
    rd(1, 8'h00, "rst_imr");
    // Init + vector
    wr(0, 8'h13); wr(1, 8'h40); wr(1, 8'h01);
    chk("init_done_set", 8'(init_done), 8'h01);
    set_irq(3, 1);
    chk("int_irq3", 8'(int_o), 8'h01);
    set_irq(3, 0);
    inta_seq(8'h43);
    chk("int_after_ack", 8'(int_o), 8'h00);
    wr(0, 8'h0B); rd(0, 8'h08, "isr_after_ack");
    // Priority / nesting
    set_irq(5, 1); set_irq(1, 1);
    chk("int_nested", 8'(int_o), 8'h01);
    inta_seq(8'h41);
    rd(0, 8'h0A, "isr_nested");
    wr(0, 8'h20); rd(0, 8'h08, "isr_ns_eoi");
    chk("int_blocked_5", 8'(int_o), 8'h00);
    wr(0, 8'h63); rd(0, 8'h00, "isr_sp_eoi");
    chk("int_irq5", 8'(int_o), 8'h01);
    inta_seq(8'h45);
    wr(0, 8'h20); set_irq(5, 0); set_irq(1, 0);
    // Mask / read
    wr(1, 8'h02); set_irq(1, 1);
    chk("int_masked", 8'(int_o), 8'h00);
    wr(0, 8'h0A); rd(0, 8'h02, "irr_masked"); rd(1, 8'h02, "imr_read");
    wr(1, 8'h00);
    chk("int_unmasked", 8'(int_o), 8'h01);
    inta_seq(8'h41); wr(0, 8'h20); set_irq(1, 0);
    // Auto-EOI
    wr(0, 8'h13); wr(1, 8'h40); wr(1, 8'h03);
    set_irq(2, 1); set_irq(2, 0);
    inta_seq(8'h42);
    wr(0, 8'h0B); rd(0, 8'h00, "isr_aeoi");
    wr(0, 8'h62); rd(0, 8'h00, "isr_eoi_noop");
    // Spurious in level mode
    wr(0, 8'h1B); wr(1, 8'h40); wr(1, 8'h01);
    set_irq(4, 1);
    chk("int_level", 8'(int_o), 8'h01);
    set_irq(4, 0);
    chk("int_withdrawn", 8'(int_o), 8'h00);
    inta_seq(8'h47);
    wr(0, 8'h0B); rd(0, 8'h00, "isr_spurious");
    // ICW1 in the middle of an INTA sequence
    wr(1, 8'h30); set_irq(0, 1);
    inta_n = 0; tick(2); inta_n = 1; tick(2);
    irq_i[0] = 0; m_irr[0] = 0;
    inta_n = 0; tick(3);
    chk("mid_vector_en", 8'(dout_en), 8'h01);
    chk("mid_vector", dout, 8'h40);
    wr(0, 8'h13);
    chk("icw1_dout_en", 8'(dout_en), 8'h00);
    chk("icw1_init_done", 8'(init_done), 8'h00);
    inta_n = 1; tick(2);
    rd(1, 8'h00, "icw1_imr");
    inta_n = 0; tick(2); inta_n = 1; tick(2); inta_n = 0; tick(3);
    chk("inta_preinit", 8'(dout_en), 8'h00);
    inta_n = 1; tick(2);
    wr(1, 8'h40); wr(1, 8'h01);
    chk("reinit_done", 8'(init_done), 8'h01);
    // Reset in the middle of an INTA sequence
    set_irq(6, 1);
    inta_n = 0; tick(2); inta_n = 1; tick(2); inta_n = 0; tick(3);
    chk("pre_rst_vector", dout, 8'h46);
    rst_n = 0; #2;
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_dout_en", 8'(dout_en), 8'h00);
    chk("mid_rst_int_o", 8'(int_o), 8'h00);
    chk("mid_rst_init_done", 8'(init_done), 8'h00);
    m_reset();
    inta_n = 1; irq_i = 0; tick(2);
    rst_n = 1; tick(2); idle(3);
    rd(1, 8'h00, "post_rst_imr");
    rd(0, 8'h00, "post_rst_irr");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
